// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
// Purpose : FSM state and owner encodings plus counter widths used by mem_arb
//           and mem_arb_pick.
// Ports   : none (package).
// Config  : MEM_ARB_RR_EN (used by mem_arb / mem_arb_pick, not here).
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_e;

  // Holds RD_LAT (1..7).
  localparam int LAT_W    = 3;
  // Holds STARVE_MAX (1..255).
  localparam int STARVE_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the two-master arbiter
// Purpose : Picks which master owns the memory port this cycle.
// Ports   : m0_req, m1_req      - raw requests
//           starve_cnt          - lost-arbitration count of m1 (fixed priority build)
//           last_granted        - most recent grantee (MEM_ARB_RR_EN build)
//           winner, valid       - selected master and "someone wins"
// Config  : MEM_ARB_RR_EN selects strict round-robin instead of CPU priority.
import mem_arb_pkg::*;

module mem_arb_pick
`ifndef MEM_ARB_RR_EN
  #(parameter int STARVE_MAX = 8)
`endif
(
  input  logic                m0_req,
  input  logic                m1_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e              last_granted,
`else
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output owner_e              winner,
  output logic                valid
);

  always_comb begin
    valid  = m0_req || m1_req;
    winner = M0;
`ifdef MEM_ARB_RR_EN
    // On a tie the master that did not win last time goes first.
    if (m1_req && (!m0_req || last_granted == M0)) winner = M1;
`else
    // CPU wins ties unless m1 has lost STARVE_MAX times in a row.
    if (m1_req && (!m0_req || starve_cnt == STARVE_W'(STARVE_MAX))) winner = M1;
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-master arbiter/sequencer for the unified instruction/data memory port
// Purpose : Serialises CPU (m0) and DMA/debug (m1) accesses onto one memory port,
//           tracks the single outstanding read and returns its data to the owner.
// Ports   : clk, rst                      - clock, async active-high reset
//           mX_req/we/adr/wdata           - master X command (held until mX_gnt)
//           mX_gnt                        - command accepted this cycle
//           mX_rvalid/rdata               - read data return (rdata 0 when not valid)
//           mem_en/we/adr/wdata, mem_rdata- memory port, read data RD_LAT cycles after command
//           busy                          - read outstanding
// Config  : MEM_ARB_RR_EN selects strict round-robin arbitration (no starvation counter).
import mem_arb_pkg::*;

module mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("mem_arb: RD_LAT out of range 1..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("mem_arb: STARVE_MAX out of range 1..255");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [LAT_W-1:0] r_lat_cnt;
  owner_e           r_owner;
  owner_e           w_winner;
  logic             w_valid;
  logic             w_win_we;
  logic             w_rd_accept;

  assign w_win_we    = (w_winner == M1) ? m1_we : m0_we;
  assign w_rd_accept = (r_state == IDLE) && w_valid && !w_win_we;

`ifdef MEM_ARB_RR_EN
  owner_e r_last_granted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_last_granted <= M1;
    else if (r_state == IDLE && w_valid) r_last_granted <= w_winner;
  end

  mem_arb_pick u_pick (
    .m0_req       (m0_req),
    .m1_req       (m1_req),
    .last_granted (r_last_granted),
    .winner       (w_winner),
    .valid        (w_valid)
  );
`else
  logic [STARVE_W-1:0] r_starve_cnt;

  // Any IDLE cycle where m1 asks but is not granted means m0 took the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (!m1_req || w_winner == M1)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_W'(STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
    end
  end

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .starve_cnt (r_starve_cnt),
    .winner     (w_winner),
    .valid      (w_valid)
  );
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rd_accept) w_next_state = RD_WAIT;
      RD_WAIT: if (r_lat_cnt == LAT_W'(1)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Read bookkeeping: who owns the outstanding read and how long until data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt <= '0;
      r_owner   <= M0;
    end else if (r_state == IDLE) begin
      if (w_rd_accept) begin
        r_owner   <= w_winner;
        r_lat_cnt <= LAT_W'(RD_LAT);
      end
    end else begin
      r_lat_cnt <= r_lat_cnt - LAT_W'(1);
    end
  end

  // Outputs are forced low while rst is high so a mid-cycle reset takes effect at once.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            mem_en = 1'b1;
            if (w_winner == M1) begin
              m1_gnt    = 1'b1;
              mem_we    = m1_we;
              mem_adr   = m1_adr;
              mem_wdata = m1_wdata;
            end else begin
              m0_gnt    = 1'b1;
              mem_we    = m0_we;
              mem_adr   = m0_adr;
              mem_wdata = m0_wdata;
            end
          end
        end
        RD_WAIT: begin
          busy = 1'b1;
          if (r_lat_cnt == LAT_W'(1)) begin
            if (r_owner == M1) begin
              m1_rvalid = 1'b1;
              m1_rdata  = mem_rdata;
            end else begin
              m0_rvalid = 1'b1;
              m0_rdata  = mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb (default build and MEM_ARB_RR_EN build)
module tb_mem_arb;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: data returned RD_LAT cycles after a read command.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] pipe [RD_LAT];
  logic          cmd_rd = 1'b0;
  logic [DW-1:0] cmd_data = '0;

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(negedge clk) begin
    cmd_rd   = mem_en && !mem_we;
    cmd_data = rd_mem(mem_adr);
    if (mem_en && mem_we) mem[mem_adr] = mem_wdata;
  end

  always @(posedge clk) begin
    pipe[0] <= cmd_rd ? cmd_data : 32'hBAD0_0000;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Scoreboard of outstanding reads.
  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en && !mem_we)
        sb.push_back('{owner: m1_gnt, data: rd_mem(mem_adr), due: cyc + RD_LAT});
      if (m0_rvalid || m1_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: m0_rvalid=%0b m1_rvalid=%0b required none", m0_rvalid, m1_rvalid);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (m1_rvalid !== e.owner || m0_rvalid === m1_rvalid ||
              (e.owner ? m1_rdata : m0_rdata) !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL rvalid_match: m0v=%0b m1v=%0b rdata=%h/%h cyc=%0d required owner=%0b data=%h cyc=%0d",
                     m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, cyc, e.owner, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL rvalid_missing: none at cyc=%0d required at cyc=%0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
    checks++;
    if ((!m0_rvalid && m0_rdata !== '0) || (!m1_rvalid && m1_rdata !== '0)) begin
      errors++;
      $display("FAIL rdata_idle_zero: m0_rdata=%h m1_rdata=%h required 0", m0_rdata, m1_rdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic m0_req;
    logic m1_req;
    logic e_m0_gnt;
    logic e_m1_gnt;
  } vec_t;
  vec_t vecs [14];

  initial begin
    // m1 starvation limit is 4: the counter is noted in each comment after the cycle.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0}; // 0
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0}; // 0
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // 0
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // 1
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // 2
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // 0
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // 1
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0}; // 0
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // 1
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // 2
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0}; // 3
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0}; // 4
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1}; // 0
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0}; // 0

    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    mem[32'h0000_0100] = 32'hDEAD_BEEF;
    mem[32'h0000_0200] = 32'h5555_AAAA;

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_adr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_adr = '0; m1_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    next_cycle();
    rst = 1'b0;

    // Asynchronous reset mid-cycle while m0 requests
    next_cycle();
    m0_req = 1; m0_we = 1; m0_adr = 32'h40; m0_wdata = 32'h41;
    @(negedge clk);
    chk("t1_gnt_before", m0_gnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_gnt_in_rst", m0_gnt, 0);
    chk("t1_mem_en_in_rst", mem_en, 0);
    chk("t1_busy_in_rst", busy, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t1_gnt_after", m0_gnt, 1);
    chk("t1_adr_after", mem_adr, 32'h40);
    next_cycle();
    m0_req = 0;

`ifndef MEM_ARB_RR_EN
    // Arbitration vector table (all writes)
    for (int i = 0; i < 14; i++) begin
      logic [31:0] exp_adr;
      m0_req = vecs[i].m0_req; m0_we = 1; m0_adr = 32'h1000 + i; m0_wdata = 32'hA000 + i;
      m1_req = vecs[i].m1_req; m1_we = 1; m1_adr = 32'h2000 + i; m1_wdata = 32'hB000 + i;
      exp_adr = vecs[i].e_m0_gnt ? 32'h1000 + i : (vecs[i].e_m1_gnt ? 32'h2000 + i : 32'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].e_m0_gnt);
      chk($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].e_m1_gnt);
      chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].e_m0_gnt | vecs[i].e_m1_gnt);
      chk($sformatf("vec%0d_mem_adr", i), mem_adr, exp_adr);
      next_cycle();
    end
    m0_req = 0; m1_req = 0;
`endif

    // Read with RD_LAT=2, requester keeps asking for a follow-up write
    m0_req = 1; m0_we = 0; m0_adr = 32'h100;
    @(negedge clk);
    chk("t2_gnt_T", m0_gnt, 1);
    chk("t2_mem_en_T", mem_en, 1);
    chk("t2_mem_we_T", mem_we, 0);
    chk("t2_mem_adr_T", mem_adr, 32'h100);
    chk("t2_busy_T", busy, 0);
    next_cycle();
    m0_we = 1; m0_adr = 32'h104; m0_wdata = 32'h5;
    @(negedge clk);
    chk("t2_busy_T1", busy, 1);
    chk("t2_gnt_T1", m0_gnt, 0);
    chk("t2_mem_en_T1", mem_en, 0);
    chk("t2_rvalid_T1", m0_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("t2_busy_T2", busy, 1);
    chk("t2_gnt_T2", m0_gnt, 0);
    chk("t2_rvalid_T2", m0_rvalid, 1);
    chk("t2_rdata_T2", m0_rdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    chk("t2_busy_T3", busy, 0);
    chk("t2_gnt_T3", m0_gnt, 1);
    chk("t2_adr_T3", mem_adr, 32'h104);
    next_cycle();
    m0_req = 0;

`ifndef MEM_ARB_RR_EN
    // Simultaneous writes: CPU first, then master 1
    m0_req = 1; m0_we = 1; m0_adr = 32'h10; m0_wdata = 32'h11;
    m1_req = 1; m1_we = 1; m1_adr = 32'h20; m1_wdata = 32'h22;
    @(negedge clk);
    chk("t3_m0_gnt", m0_gnt, 1);
    chk("t3_m1_gnt_T", m1_gnt, 0);
    chk("t3_adr_T", mem_adr, 32'h10);
    chk("t3_wdata_T", mem_wdata, 32'h11);
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    chk("t3_m1_gnt", m1_gnt, 1);
    chk("t3_adr_T1", mem_adr, 32'h20);
    chk("t3_wdata_T1", mem_wdata, 32'h22);
    next_cycle();
    m1_req = 0;

    // Starvation: m1 loses STARVE_MAX times then wins, twice over
    m0_req = 1; m0_we = 1; m0_adr = 32'h400;
    m1_req = 1; m1_we = 1; m1_adr = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= STARVE_MAX; k++) begin
        @(negedge clk);
        chk($sformatf("t4_r%0d_k%0d_m0_gnt", r, k), m0_gnt, (k != STARVE_MAX));
        chk($sformatf("t4_r%0d_k%0d_m1_gnt", r, k), m1_gnt, (k == STARVE_MAX));
        next_cycle();
        m0_adr = m0_adr + 4;
      end
    end
    m0_req = 0; m1_req = 0;
    next_cycle();
`endif

    // Master 1 read killed by reset while waiting
    m1_req = 1; m1_we = 0; m1_adr = 32'h200;
    @(negedge clk);
    chk("t5_m1_gnt", m1_gnt, 1);
    next_cycle();
    m1_req = 0;
    @(negedge clk);
    chk("t5_busy_T1", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy_in_rst", busy, 0);
    chk("t5_rvalid_in_rst", m1_rvalid, 0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_no_rvalid_%0d", k), m1_rvalid, 0);
      chk($sformatf("t5_busy_%0d", k), busy, 0);
    end
    next_cycle();

`ifdef MEM_ARB_RR_EN
    // Round-robin alternation from reset
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m0_req = 1; m0_we = 1; m0_adr = 32'h500; m0_wdata = 32'h1;
    m1_req = 1; m1_we = 1; m1_adr = 32'h600; m1_wdata = 32'h2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t6_%0d_m0_gnt", k), m0_gnt, (k % 2 == 0));
      chk($sformatf("t6_%0d_m1_gnt", k), m1_gnt, (k % 2 == 1));
      next_cycle();
    end
    m0_req = 0; m1_req = 0;
    next_cycle();
`endif

    repeat (RD_LAT + 1) next_cycle();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
